fdau_frame_reader: RTL and testbench

Read-side counterpart of the FDAU frame writer. Once per frame trigger, it reads the assembled frame from the 512-word fdau_ram read port. It wraps the frame as sync word, data words, then checksum. The result goes out as a byte stream with valid/ready handshake, feeding the UART/TX link to the LPC & MK.

---
 rtl/fdau_pkg.sv | 19 +
 rtl/fdau_word_serializer.sv | 51 +++++
 rtl/fdau_frame_reader.sv | 158 +++++++++++++++
 tb/tb_fdau_frame_reader.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fdau_pkg.sv
// Shared types and defaults for the FDAU frame read path.
// Default frame: 66 ADC + 3 taho/impuls + 6x32 ARINC words.
package fdau_pkg;

    localparam int          ADDR_W          = 9;
    localparam int          DATA_W          = 16;
    localparam int          FRAME_WORDS_DEF = 261;
    localparam logic [15:0] SYNC_WORD_DEF   = 16'hA55A;

    // Low/high byte phases live in the serializer, so one state covers each word kind.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_RD_WAIT,
        ST_DATA,
        ST_CSUM
    } readerState_e;

endpackage

// File: rtl/fdau_word_serializer.sv
// Emits a loaded 16-bit word as low byte then high byte over valid/ready.
// A new word may be loaded in the same cycle the previous high byte is taken.
module fdau_word_serializer
    import fdau_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              i_load,
    input  logic [DATA_W-1:0] i_word,
    input  logic              i_byteReady,
    output logic [7:0]        o_byteData,
    output logic              o_byteValid,
    output logic              o_hiPhase,
    output logic              o_wordTaken
);

    logic [7:0] r_byteData;
    logic [7:0] r_hiByte;
    logic       r_valid;
    logic       r_hiPhase;
    logic       w_xfer;

    assign w_xfer      = r_valid & i_byteReady;
    assign o_wordTaken = w_xfer & r_hiPhase;
    assign o_byteData  = r_byteData;
    assign o_byteValid = r_valid;
    assign o_hiPhase   = r_hiPhase;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_byteData <= 8'h00;
            r_hiByte   <= 8'h00;
            r_valid    <= 1'b0;
            r_hiPhase  <= 1'b0;
        end else if (i_load) begin
            r_valid    <= 1'b1;
            r_byteData <= i_word[7:0];
            r_hiByte   <= i_word[15:8];
            r_hiPhase  <= 1'b0;
        end else if (w_xfer) begin
            if (r_hiPhase) begin
                r_valid   <= 1'b0;
                r_hiPhase <= 1'b0;
            end else begin
                r_byteData <= r_hiByte;
                r_hiPhase  <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/fdau_frame_reader.sv
// Reads one frame from fdau_ram per trigger and streams sync, data and checksum
// as bytes (low byte first) toward the UART/TX link.
module fdau_frame_reader
    import fdau_pkg::*;
#(
    parameter int                FRAME_WORDS = FRAME_WORDS_DEF,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
    parameter int                RD_LATENCY  = 2,
    parameter logic [DATA_W-1:0] SYNC_WORD   = SYNC_WORD_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    output logic [ADDR_W-1:0] rd_fdau,
    input  logic [DATA_W-1:0] q_fdau,
    output logic [7:0]        byte_data,
    output logic              byte_valid,
    input  logic              byte_ready,
    output logic              busy,
    output logic              frame_done,
    output logic              overrun
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(FRAME_WORDS - 1);
    localparam logic [1:0]        LAT      = 2'(RD_LATENCY);

    readerState_e      r_state;
    readerState_e      w_nextState;
    logic [ADDR_W-1:0] r_rdAddr;
    logic [ADDR_W-1:0] r_wordCnt;
    logic [DATA_W-1:0] r_word;
    logic [DATA_W-1:0] r_checksum;
    logic [1:0]        r_age;
    logic              r_frameDone;

    logic              w_load;
    logic [DATA_W-1:0] w_loadWord;
    logic              w_byteValid;
    logic              w_hiPhase;
    logic              w_wordTaken;
    logic              w_loXfer;
    logic              w_ageReached;
    logic              w_lastWord;

    assign w_loXfer     = w_byteValid & byte_ready & ~w_hiPhase;
    assign w_ageReached = (r_age == LAT);
    assign w_lastWord   = (r_wordCnt == LAST_IDX);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_IDLE:    if (start)        w_nextState = ST_SYNC;
            ST_SYNC:    if (w_wordTaken)  w_nextState = ST_RD_WAIT;
            ST_RD_WAIT: if (w_ageReached) w_nextState = ST_DATA;
            ST_DATA:    if (w_wordTaken)  w_nextState = w_lastWord ? ST_CSUM : ST_RD_WAIT;
            ST_CSUM:    if (w_wordTaken)  w_nextState = ST_IDLE;
            default:                      w_nextState = ST_IDLE;
        endcase
    end

    // The checksum word is loaded as the last data high byte goes, so it follows back-to-back.
    always_comb begin
        w_load     = 1'b0;
        w_loadWord = SYNC_WORD;
        case (r_state)
            ST_IDLE: begin
                w_load = start;
            end
            ST_RD_WAIT: begin
                w_load     = w_ageReached;
                w_loadWord = q_fdau;
            end
            ST_DATA: begin
                w_load     = w_wordTaken & w_lastWord;
                w_loadWord = r_checksum;
            end
            default: begin
                w_load = 1'b0;
            end
        endcase
    end

    assign busy       = (r_state != ST_IDLE);
    assign overrun    = start & busy;
    assign frame_done = r_frameDone;
    assign rd_fdau    = r_rdAddr;
    assign byte_valid = w_byteValid;

    // r_age counts cycles since rd_fdau last changed, saturating at the RAM latency.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_rdAddr    <= BASE_ADDR;
            r_wordCnt   <= '0;
            r_word      <= '0;
            r_checksum  <= '0;
            r_age       <= 2'd0;
            r_frameDone <= 1'b0;
        end else begin
            r_frameDone <= 1'b0;
            r_age       <= w_ageReached ? r_age : r_age + 2'd1;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_checksum <= '0;
                        r_wordCnt  <= '0;
                        r_rdAddr   <= BASE_ADDR;
                        r_age      <= 2'd0;
                    end
                end
                ST_RD_WAIT: begin
                    if (w_ageReached) begin
                        r_word <= q_fdau;
                    end
                end
                ST_DATA: begin
                    if (w_loXfer) begin
                        r_checksum <= r_checksum + r_word;
                        r_rdAddr   <= r_rdAddr + 1'b1;
                        r_age      <= 2'd0;
                    end
                    if (w_wordTaken && !w_lastWord) begin
                        r_wordCnt <= r_wordCnt + 1'b1;
                    end
                end
                ST_CSUM: begin
                    if (w_wordTaken) begin
                        r_frameDone <= 1'b1;
                        r_rdAddr    <= BASE_ADDR;
                    end
                end
                default: begin
                    r_frameDone <= 1'b0;
                end
            endcase
        end
    end

    fdau_word_serializer u_serializer (
        .clock       (clock),
        .reset       (reset),
        .i_load      (w_load),
        .i_word      (w_loadWord),
        .i_byteReady (byte_ready),
        .o_byteData  (byte_data),
        .o_byteValid (w_byteValid),
        .o_hiPhase   (w_hiPhase),
        .o_wordTaken (w_wordTaken)
    );

endmodule

// File: tb/tb_fdau_frame_reader.sv
// Self-checking bench: four reader instances (latency 1/2/3, wrapped base) against a
// frame-level model of the byte stream, busy, overrun and frame_done.
module tb_fdau_frame_reader;

    localparam int NI = 4;

    logic          clock;
    logic          reset;
    logic [NI-1:0] start;
    logic [NI-1:0] byteReady;
    logic [NI-1:0] byteValid;
    logic [NI-1:0] busy;
    logic [NI-1:0] frameDone;
    logic [NI-1:0] overrun;
    logic [8:0]    rdAddr   [NI];
    logic [15:0]   qData    [NI];
    logic [7:0]    byteData [NI];

    logic [15:0]   mem      [NI][512];
    logic [7:0]    xferLog  [NI][64];
    int            xferCnt  [NI];
    int            rdLog    [16];
    int            rdLogCnt;
    bit            stallMode;

    int checks   = 0;
    int failures = 0;

    logic [7:0] expT1 [12] = '{8'h5A, 8'hA5, 8'h00, 8'h00, 8'h01, 8'h00,
                               8'h02, 8'h00, 8'h03, 8'h00, 8'h06, 8'h00};
    logic [7:0] expT3 [12] = '{8'h5A, 8'hA5, 8'hFF, 8'hFF, 8'h01, 8'h00,
                               8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    logic [7:0] expT4 [12] = '{8'h5A, 8'hA5, 8'hFE, 8'hB1, 8'hFF, 8'hB1,
                               8'h00, 8'hB0, 8'h01, 8'hB0, 8'hFE, 8'hC3};

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    task automatic stepCycles(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic [NI-1:0] mask);
        start = mask;
        stepCycles(1);
        start = '0;
    endtask

    task automatic waitDone(input int idx, input int budget, input string name, output int busyCycles);
        busyCycles = 0;
        for (int c = 0; c < budget; c++) begin
            if (frameDone[idx]) break;
            busyCycles += int'(busy[idx]);
            stepCycles(1);
        end
        checkOutput(name, frameDone[idx], 1);
    endtask

    task automatic checkLog(input int idx, input string tag, input logic [7:0] expv [12], input int n);
        checkOutput({tag, "_count"}, xferCnt[idx], n);
        for (int i = 0; i < n; i++) begin
            checkOutput($sformatf("%s_byte%0d", tag, i), xferLog[idx][i], expv[i]);
        end
    endtask

    // byte_ready driver: instance 0 accepts one cycle in three while stalling
    initial begin
        int ph = 0;
        byteReady = '1;
        forever begin
            @(posedge clock);
            #1;
            byteReady = stallMode ? {{(NI-1){1'b1}}, (ph == 0)} : '1;
            ph = (ph + 1) % 3;
        end
    end

    for (genvar g = 0; g < NI; g++) begin : inst
        localparam int FW   = (g == 1 || g == 2) ? 2 : 4;
        localparam int BASE = (g == 3) ? 510 : 0;
        localparam int LAT  = (g == 1) ? 1 : ((g == 2) ? 3 : 2);

        logic [15:0] pipe [3];
        logic [7:0]  expQ [$];
        logic [7:0]  prevData;
        logic [15:0] cs;
        logic [15:0] w;
        logic [8:0]  lastRd;
        bit          mBusy;
        bit          mDone;
        bit          nextDone;
        bit          busyNow;
        bit          prevStall;
        int          sent;
        int          total;

        always @(posedge clock) begin
            pipe[0] <= mem[g][rdAddr[g]];
            pipe[1] <= pipe[0];
            pipe[2] <= pipe[1];
        end
        assign qData[g] = pipe[LAT-1];

        fdau_frame_reader #(
            .FRAME_WORDS (FW),
            .BASE_ADDR   (9'(BASE)),
            .RD_LATENCY  (LAT),
            .SYNC_WORD   (16'hA55A)
        ) dut (
            .clock      (clock),
            .reset      (reset),
            .start      (start[g]),
            .rd_fdau    (rdAddr[g]),
            .q_fdau     (qData[g]),
            .byte_data  (byteData[g]),
            .byte_valid (byteValid[g]),
            .byte_ready (byteReady[g]),
            .busy       (busy[g]),
            .frame_done (frameDone[g]),
            .overrun    (overrun[g])
        );

        always @(negedge clock) begin
            if (reset) begin
                expQ.delete();
                mBusy     = 1'b0;
                mDone     = 1'b0;
                prevStall = 1'b0;
                sent      = 0;
                total     = 0;
                lastRd    = 9'(BASE);
            end else begin
                busyNow = mBusy;
                checkOutput($sformatf("i%0d_busy", g), busy[g], busyNow);
                checkOutput($sformatf("i%0d_overrun", g), overrun[g], start[g] & busyNow);
                checkOutput($sformatf("i%0d_frame_done", g), frameDone[g], mDone);
                if (prevStall) begin
                    checkOutput($sformatf("i%0d_hold_valid", g), byteValid[g], 1);
                    checkOutput($sformatf("i%0d_hold_data", g), byteData[g], prevData);
                end
                nextDone = 1'b0;
                if (byteValid[g] && byteReady[g]) begin
                    checkOutput($sformatf("i%0d_byte_expected", g), int'(expQ.size() > 0), 1);
                    if (expQ.size() > 0) begin
                        checkOutput($sformatf("i%0d_byte%0d", g, sent), byteData[g], expQ.pop_front());
                    end
                    if (xferCnt[g] < 64) begin
                        xferLog[g][xferCnt[g]] = byteData[g];
                        xferCnt[g]++;
                    end
                    sent++;
                    if (sent == total) begin
                        mBusy    = 1'b0;
                        nextDone = 1'b1;
                    end
                end
                if (start[g] && !busyNow) begin
                    expQ.delete();
                    expQ.push_back(8'h5A);
                    expQ.push_back(8'hA5);
                    cs = 16'h0000;
                    for (int i = 0; i < FW; i++) begin
                        w  = mem[g][(BASE + i) % 512];
                        cs = cs + w;
                        expQ.push_back(w[7:0]);
                        expQ.push_back(w[15:8]);
                    end
                    expQ.push_back(cs[7:0]);
                    expQ.push_back(cs[15:8]);
                    total = 2 * FW + 4;
                    sent  = 0;
                    mBusy = 1'b1;
                end
                mDone     = nextDone;
                prevStall = byteValid[g] & ~byteReady[g];
                prevData  = byteData[g];
                if (g == 3 && rdAddr[g] != lastRd) begin
                    if (rdLogCnt < 16) begin
                        rdLog[rdLogCnt] = int'(rdAddr[g]);
                        rdLogCnt++;
                    end
                    lastRd = rdAddr[g];
                end
            end
        end
    end

    initial begin
        int bc;
        reset     = 1'b1;
        start     = '0;
        stallMode = 1'b0;
        rdLogCnt  = 0;
        for (int n = 0; n < 512; n++) begin
            mem[0][n] = 16'(n);
            mem[1][n] = 16'h0000;
            mem[2][n] = 16'h0000;
            mem[3][n] = 16'hB000 | 16'(n);
        end
        mem[1][0] = 16'hFFFF;  mem[1][1] = 16'h0001;
        mem[2][0] = 16'hFFFF;  mem[2][1] = 16'h0001;
        for (int i = 0; i < NI; i++) xferCnt[i] = 0;

        stepCycles(3);
        reset = 1'b0;
        stepCycles(1);
        $display("[TB] reset state");
        checkOutput("rst_valid0", byteValid[0], 0);
        checkOutput("rst_data0", byteData[0], 0);
        checkOutput("rst_busy0", busy[0], 0);
        checkOutput("rst_done0", frameDone[0], 0);
        checkOutput("rst_rd0", rdAddr[0], 0);
        checkOutput("rst_rd3", rdAddr[3], 510);

        $display("[TB] basic frame");
        xferCnt[0] = 0;
        applyStimulus(4'b0001);
        checkOutput("t1_busy_after_start", busy[0], 1);
        checkOutput("t1_first_byte", byteData[0], 8'h5A);
        waitDone(0, 100, "t1_done", bc);
        checkOutput("t1_busy_ge12", int'(bc >= 12), 1);
        checkOutput("t1_busy_in_done", busy[0], 0);
        checkLog(0, "t1", expT1, 12);
        stepCycles(2);

        $display("[TB] stalled sink");
        stallMode = 1'b1;
        xferCnt[0] = 0;
        applyStimulus(4'b0001);
        waitDone(0, 300, "t2_done", bc);
        checkLog(0, "t2", expT1, 12);
        stallMode = 1'b0;
        stepCycles(2);

        $display("[TB] read latency 1 and 3");
        xferCnt[1] = 0;
        xferCnt[2] = 0;
        applyStimulus(4'b0110);
        waitDone(1, 100, "t3_done_lat1", bc);
        waitDone(2, 100, "t3_done_lat3", bc);
        checkLog(1, "t3_lat1", expT3, 8);
        checkLog(2, "t3_lat3", expT3, 8);
        stepCycles(2);

        $display("[TB] address wrap");
        xferCnt[3] = 0;
        rdLogCnt   = 0;
        applyStimulus(4'b1000);
        waitDone(3, 100, "t4_done", bc);
        checkLog(3, "t4", expT4, 12);
        checkOutput("t4_rd_a", rdLog[0], 511);
        checkOutput("t4_rd_b", rdLog[1], 0);
        checkOutput("t4_rd_c", rdLog[2], 1);
        checkOutput("t4_rd_home", rdAddr[3], 510);
        stepCycles(2);

        $display("[TB] overrun and restart on frame_done");
        xferCnt[0] = 0;
        applyStimulus(4'b0001);
        stepCycles(4);
        start[0] = 1'b1;
        #1;
        checkOutput("t5_overrun_mid", overrun[0], 1);
        stepCycles(1);
        start[0] = 1'b0;
        waitDone(0, 100, "t5_done", bc);
        checkLog(0, "t5", expT1, 12);
        xferCnt[0] = 0;
        start[0] = 1'b1;
        #1;
        checkOutput("t5_overrun_at_done", overrun[0], 0);
        stepCycles(1);
        start[0] = 1'b0;
        checkOutput("t5_restart_busy", busy[0], 1);
        checkOutput("t5_restart_valid", byteValid[0], 1);
        checkOutput("t5_restart_byte", byteData[0], 8'h5A);
        waitDone(0, 100, "t5_done2", bc);
        checkLog(0, "t5b", expT1, 12);
        stepCycles(2);

        $display("[TB] reset during data high byte");
        xferCnt[0] = 0;
        applyStimulus(4'b0001);
        for (int c = 0; c < 50; c++) begin
            if (xferCnt[0] == 3) break;
            stepCycles(1);
        end
        checkOutput("t6_in_data_hi", byteValid[0], 1);
        reset = 1'b1;
        stepCycles(1);
        reset = 1'b0;
        checkOutput("t6_valid", byteValid[0], 0);
        checkOutput("t6_busy", busy[0], 0);
        checkOutput("t6_rd", rdAddr[0], 0);
        checkOutput("t6_done", frameDone[0], 0);
        stepCycles(2);
        xferCnt[0] = 0;
        applyStimulus(4'b0001);
        waitDone(0, 100, "t6_done_after", bc);
        checkLog(0, "t6", expT1, 12);
        stepCycles(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
